prog_instruction_memory: RTL
============================

Name: prog_instruction_memory

Overview:
- Parametrised successor to the fixed instruction ROM.
- Word-addressed instruction store sitting between the fetch-stage PC and the IF/ID register.
- Adds a run-time programming port with a valid/ready handshake, a bulk-clear engine, an optional registered read, and alignment/range error detection.
- The fetch side sees NOP (32'h00000000) and instr_valid=0 whenever the store is being programmed or cleared.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 1024 (INST_MEM_SIZE), number of words; power of two.
- IDX_W, log2(DEPTH), word-index width; addr[IDX_W+1:2] selects the word.
- REG_READ, 0, 0 = combinational read (latency 0); 1 = registered read (latency 1).
- NOP_WORD, 32'h00000000, word returned on invalid or blocked fetch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  fetch request qualifier.
- fetch_addr  in  32  byte address (PC).
- instruction  out  DATA_W  fetched word.
- instr_valid  out  1  instruction is a real fetch result.
- addr_err  out  1  fetch misaligned or out of range.
- prog_start  in  1  one-cycle pulse: begin load at prog_base.
- prog_base  in  IDX_W  starting word index.
- prog_valid  in  1  prog_data valid.
- prog_data  in  DATA_W  word to store.
- prog_last  in  1  marks final word of load.
- prog_ready  out  1  accepts a word this cycle.
- prog_done  out  1  one-cycle pulse at end of load or clear.
- prog_ovf  out  1  sticky: a load word was dropped past DEPTH-1.
- clear_req  in  1  one-cycle pulse: fill memory with NOP_WORD.
- busy  out  1  state != RUN.

Behaviour:
- Reset values:
  - state=RUN, wr_ptr=0.
  - instruction=NOP_WORD, instr_valid=0, addr_err=0.
  - prog_ready=0, prog_done=0, prog_ovf=0.
- Reset does not alter array contents.
- FSM states RUN, LOAD, CLEAR:
  - RUN: clear_req -> CLEAR with ptr=0. Otherwise prog_start -> LOAD with ptr=prog_base and prog_ovf cleared. If both fire in the same cycle, clear wins.
  - LOAD:
    - prog_ready=1.
    - A word is accepted on prog_valid & prog_ready. It is written to mem[ptr] and ptr increments.
    - If the accepted word has prog_last=1, go to RUN and pulse prog_done the next cycle.
    - A word accepted when ptr has passed DEPTH-1 is dropped and prog_ovf is set. ptr does not wrap.
    - prog_start in LOAD restarts at the new prog_base; the word on that cycle is ignored.
    - clear_req in LOAD goes to CLEAR.
  - CLEAR:
    - Writes NOP_WORD to mem[ptr] once per cycle, ptr from 0 to DEPTH-1. This takes DEPTH cycles.
    - Then go to RUN and pulse prog_done. prog_start and clear_req are ignored during CLEAR.
- Fetch in RUN with fetch_en=1:
  - misaligned = fetch_addr[1:0] != 0.
  - out_of_range = fetch_addr[31:IDX_W+2] != 0.
  - If either is true: instruction=NOP_WORD, instr_valid=0, addr_err=1.
  - Otherwise: instruction=mem[fetch_addr[IDX_W+1:2]], instr_valid=1, addr_err=0.
- Fetch with fetch_en=0 or state != RUN: instruction=NOP_WORD, instr_valid=0, addr_err=0.
- REG_READ=0: outputs are combinational from the current inputs and state.
- REG_READ=1: outputs register the above on the next clk edge. A fetch issued in the last LOAD/CLEAR cycle returns NOP with instr_valid=0.
- Read-during-write at the same index in LOAD cannot occur, because fetch is blocked while not in RUN.
- Reset mid-LOAD or mid-CLEAR: return to RUN immediately. Partial contents are retained, and no prog_done is issued.

Decomposition:
- Shared package/defines:
  - INST_MEM_SIZE, NOP_WORD, DATA_W.
  - State encodings ST_RUN=2'd0, ST_LOAD=2'd1, ST_CLEAR=2'd2.
- One natural sub-module, imem_array: a single-write-port, single-read-port RAM with a REG_READ option.
- The controller FSM, pointer, and error logic stay in the top module.

Test Plan:
- Reset, then clear_req; wait DEPTH cycles -> prog_done pulses exactly once at cycle DEPTH+1; fetch 0x0, 0x4, 0xFFC all return 32'h00000000 with instr_valid=1.
- prog_start with base=0, then stream 32'h02114020, 32'h01134821, 32'h02945022 (last) with prog_valid toggling 1,0,1,1 -> 3 writes, prog_done pulses; fetch 0x4 returns 32'h01134821 (REG_READ=0: same cycle; REG_READ=1: next cycle).
- Fetch 0x6 -> addr_err=1, instr_valid=0, instruction=0; fetch 0x1000 with DEPTH=1024 -> addr_err=1.
- Load with base=1022 and 4 words -> mem[1022] and mem[1023] written, prog_ovf=1; a later prog_start clears prog_ovf to 0.
- prog_start and clear_req in the same RUN cycle -> enters CLEAR; fetch during CLEAR returns instr_valid=0 and busy=1.
- Assert rst_n low mid-LOAD after 2 of 5 words -> state RUN, no prog_done, and both written words are readable.

Source files
------------

// File: rtl/prog_instruction_memory_pkg.sv
// Shared constants and controller state encoding for the programmable
// instruction store.
package prog_instruction_memory_pkg;

  localparam int          INST_MEM_SIZE = 1024;
  localparam int          DATA_W        = 32;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/prog_instruction_memory_array.sv
// Single-write, single-read word RAM; the read port is either
// combinational or registered depending on REG_READ.
module prog_instruction_memory_array #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter bit REG_READ = 1'b0
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  if (REG_READ) begin : g_reg_read
    logic [DATA_W-1:0] r_rdata;
    always_ff @(posedge clk) begin
      r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
  end else begin : g_comb_read
    assign o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/prog_instruction_memory.sv
// Instruction store with a run-time load port, bulk-clear engine and
// fetch-side alignment/range checking.
module prog_instruction_memory #(
  parameter int                DATA_W   = prog_instruction_memory_pkg::DATA_W,
  parameter int                DEPTH    = prog_instruction_memory_pkg::INST_MEM_SIZE,
  parameter int                IDX_W    = $clog2(DEPTH),
  parameter bit                REG_READ = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD = prog_instruction_memory_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_err,
  input  logic              prog_start,
  input  logic [IDX_W-1:0]  prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_ovf,
  input  logic              clear_req,
  output logic              busy
);
  import prog_instruction_memory_pkg::*;

  // One extra pointer bit lets a load run past the top without wrapping.
  localparam int               PTR_W    = IDX_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);

  state_t            r_state, w_next;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_ovf, r_done;
  logic              w_accept, w_in_range, w_clear_end;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr, w_raddr;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic              w_misalign, w_oor, w_fetch_act, w_fetch_ok, w_fetch_err;

  // A restart or clear request in LOAD takes priority over the word on that cycle.
  assign w_accept    = (r_state == ST_LOAD) && prog_valid && !prog_start && !clear_req;
  assign w_in_range  = (r_ptr < DEPTH_P);
  assign w_clear_end = (r_state == ST_CLEAR) && (r_ptr == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (clear_req)       w_next = ST_CLEAR;
        else if (prog_start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (clear_req)                  w_next = ST_CLEAR;
        else if (prog_start)            w_next = ST_LOAD;
        else if (w_accept && prog_last) w_next = ST_RUN;
      end
      ST_CLEAR: begin
        if (w_clear_end) w_next = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr[IDX_W-1:0];
    w_wdata = prog_data;
    case (r_state)
      ST_LOAD:  w_we = w_accept && w_in_range;
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_wdata = NOP_WORD;
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN, ST_LOAD: begin
          if (clear_req) begin
            r_ptr <= '0;
          end else if (prog_start) begin
            r_ptr <= {1'b0, prog_base};
            r_ovf <= 1'b0;
          end else if (w_accept) begin
            if (w_in_range) r_ptr <= r_ptr + 1'b1;
            else            r_ovf <= 1'b1;
            if (prog_last)  r_done <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (w_clear_end) r_done <= 1'b1;
        end
        default: r_ptr <= '0;
      endcase
    end
  end

  assign prog_ready = (r_state == ST_LOAD);
  assign busy       = (r_state != ST_RUN);
  assign prog_done  = r_done;
  assign prog_ovf   = r_ovf;

  assign w_misalign  = |fetch_addr[1:0];
  assign w_oor       = |(fetch_addr >> (IDX_W + 2));
  assign w_fetch_act = fetch_en && (r_state == ST_RUN);
  assign w_fetch_ok  = w_fetch_act && !w_misalign && !w_oor;
  assign w_fetch_err = w_fetch_act && (w_misalign || w_oor);
  assign w_raddr     = fetch_addr[IDX_W+1:2];

  prog_instruction_memory_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .REG_READ(REG_READ)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // With a registered read the qualifiers are delayed to line up with the data.
  if (REG_READ) begin : g_reg_out
    logic r_hit, r_err;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hit <= 1'b0;
        r_err <= 1'b0;
      end else begin
        r_hit <= w_fetch_ok;
        r_err <= w_fetch_err;
      end
    end
    assign instruction = r_hit ? w_rdata : NOP_WORD;
    assign instr_valid = r_hit;
    assign addr_err    = r_err;
  end else begin : g_comb_out
    assign instruction = w_fetch_ok ? w_rdata : NOP_WORD;
    assign instr_valid = w_fetch_ok;
    assign addr_err    = w_fetch_err;
  end

endmodule
